// File: rtl/axi_slave_mem_pkg.sv
// Shared types and helpers for the AXI4 slave memory responder.
// Latency: n/a (package). Backpressure: n/a.
// Holds response/burst codes, write/read FSM state enums and the burst legality check.
package axi_slave_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Returns 1 when a burst must be answered with SLVERR: wrong beat size,
    // WRAP/reserved burst type, or any beat landing outside the memory.
    // INCR is range-checked on its last beat, FIXED only on its start.
    function automatic logic mem_burst_err(
        input logic [63:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input int unsigned size_log2,
        input int unsigned depth_log2
    );
        logic [63:0] first_idx;
        logic [63:0] last_idx;
        logic        size_err;
        logic        burst_err;
        logic        range_err;
        first_idx = addr >> size_log2;
        last_idx  = (burst == BURST_INCR) ? first_idx + {56'd0, len} : first_idx;
        size_err  = (size != size_log2[2:0]);
        burst_err = (burst == BURST_WRAP) || (burst == 2'b11);
        range_err = ((last_idx >> depth_log2) != 64'd0);
        return size_err || burst_err || range_err;
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between a master agent and the slave memory.
// Latency: n/a (wires only). Backpressure: standard AXI valid/ready on every channel.
// Modports: master drives requests/data/ready-for-responses, slave drives the rest.
interface axi_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_slave_mem_ram.sv
// Byte-enabled RAM, one write port and one read port, registered read data.
// Latency: 1 cycle read (data valid the cycle after re_i); write commits at the clock edge.
// Backpressure: none; rdata_o holds its value while re_i is low.
// Ports: clk_i/rst_i, we_i/waddr_i/wdata_i/wstrb_i (write), re_i/raddr_i/rdata_o (read).
module axi_slave_mem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read samples the pre-write contents, so a same-cycle read/write to one word returns old data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave terminating FIXED/INCR bursts (<=256 beats) in a word-addressed memory.
// Latency: B one cycle after the last W beat; first R beat one cycle after the AR handshake, then one per cycle.
// Backpressure: B and R outputs hold while the master is not ready; AXI_SLV_STALL_EN adds LFSR-driven W/R wait states.
// Ports: ACLK, ARESET (async, active high), axi (slave modport of axi_slave_mem_if).
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic           ACLK,
    input  logic           ARESET,
    axi_slave_mem_if.slave axi
);
    localparam int unsigned SZ_LOG2 = $clog2(DATA_WIDTH/8);
    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);

    logic stall;
`ifdef AXI_SLV_STALL_EN
    // x^4+x^3+1 LFSR; bit 0 inserts wait states on W acceptance and R beat fetch.
    logic [3:0] lfsr_q;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) lfsr_q <= 4'b1001;
        else        lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    assign aw_addr = axi.AWADDR;
    assign ar_addr = axi.ARADDR;
    assign aw_idx  = IDX_W'(aw_addr >> SZ_LOG2);
    assign ar_idx  = IDX_W'(ar_addr >> SZ_LOG2);

    // ---------------- write path ----------------
    w_state_t              wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [IDX_W-1:0]      widx_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic                  winc_q, werr_q;
    logic                  awready, wready, bvalid;
    logic                  aw_hs, w_hs;

    assign aw_hs = axi.AWVALID && awready;
    assign w_hs  = axi.WVALID && wready;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wstate_q <= W_IDLE;
        else        wstate_q <= wstate_d;
    end

    always_comb begin
        wstate_d = wstate_q;
        unique case (wstate_q)
            W_IDLE:  if (aw_hs)              wstate_d = W_DATA;
            W_DATA:  if (w_hs && axi.WLAST)  wstate_d = W_RESP;
            W_RESP:  if (axi.BREADY)         wstate_d = W_IDLE;
            default:                         wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (wstate_q == W_IDLE);
        wready  = (wstate_q == W_DATA) && !stall;
        bvalid  = (wstate_q == W_RESP);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wid_q  <= '0;
            widx_q <= '0;
            wlen_q <= '0;
            wcnt_q <= '0;
            winc_q <= 1'b0;
            werr_q <= 1'b0;
        end else if (aw_hs) begin
            wid_q  <= axi.AWID;
            widx_q <= aw_idx;
            wlen_q <= axi.AWLEN;
            wcnt_q <= '0;
            winc_q <= (axi.AWBURST == BURST_INCR);
            werr_q <= mem_burst_err(64'(aw_addr), axi.AWLEN, axi.AWSIZE, axi.AWBURST,
                                    SZ_LOG2, IDX_W);
        end else if (w_hs) begin
            wcnt_q <= wcnt_q + 8'd1;
            if (winc_q) widx_q <= widx_q + IDX_W'(1);
            // WLAST disagreeing with AWLEN (early or late) poisons the burst; once
            // set, err also blocks any overrun beats from reaching memory.
            if (axi.WLAST != (wcnt_q == wlen_q)) werr_q <= 1'b1;
        end
    end

    assign axi.AWREADY = awready;
    assign axi.WREADY  = wready;
    assign axi.BVALID  = bvalid;
    assign axi.BID     = wid_q;
    assign axi.BRESP   = (bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read path ----------------
    r_state_t              rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [IDX_W-1:0]      ridx_q, rd_idx;
    logic [7:0]            rlen_q, rcnt_q;
    logic                  rinc_q, rerr_q, rvalid_q, rneed_q;
    logic                  arready, rlast, ar_hs, r_hs, rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign ar_hs = axi.ARVALID && arready;
    assign r_hs  = rvalid_q && axi.RREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rstate_q <= R_IDLE;
        else        rstate_q <= rstate_d;
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            R_IDLE:  if (ar_hs)          rstate_d = R_DATA;
            R_DATA:  if (r_hs && rlast)  rstate_d = R_IDLE;
            default:                     rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (rstate_q == R_IDLE);
        rlast   = rvalid_q && (rcnt_q == rlen_q);
    end

    // Beat fetch: the RAM read is issued in the cycle a beat becomes owed (AR
    // handshake or consumption of the previous beat) so it is presented next
    // cycle. A stalled fetch leaves rneed_q set and retries each cycle.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = ridx_q;
        if (ar_hs) begin
            rd_en  = !stall;
            rd_idx = ar_idx;
        end else if (r_hs && !rlast) begin
            rd_en  = !stall;
            rd_idx = rinc_q ? ridx_q + IDX_W'(1) : ridx_q;
        end else if (rneed_q) begin
            rd_en  = !stall;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rinc_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rneed_q  <= 1'b0;
        end else if (ar_hs) begin
            rid_q    <= axi.ARID;
            ridx_q   <= rd_idx;
            rlen_q   <= axi.ARLEN;
            rcnt_q   <= '0;
            rinc_q   <= (axi.ARBURST == BURST_INCR);
            rerr_q   <= mem_burst_err(64'(ar_addr), axi.ARLEN, axi.ARSIZE, axi.ARBURST,
                                      SZ_LOG2, IDX_W);
            rvalid_q <= !stall;
            rneed_q  <= stall;
        end else if (r_hs) begin
            if (rlast) begin
                rvalid_q <= 1'b0;
            end else begin
                rcnt_q   <= rcnt_q + 8'd1;
                ridx_q   <= rd_idx;
                rvalid_q <= !stall;
                rneed_q  <= stall;
            end
        end else if (rneed_q && !stall) begin
            rvalid_q <= 1'b1;
            rneed_q  <= 1'b0;
        end
    end

    assign axi.ARREADY = arready;
    assign axi.RVALID  = rvalid_q;
    assign axi.RLAST   = rlast;
    assign axi.RID     = rid_q;
    assign axi.RDATA   = rerr_q ? '0 : ram_rdata;
    assign axi.RRESP   = rerr_q ? RESP_SLVERR : RESP_OKAY;

    axi_slave_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .we_i    (w_hs && !werr_q),
        .waddr_i (widx_q),
        .wdata_i (axi.WDATA),
        .wstrb_i (axi.WSTRB),
        .re_i    (rd_en),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );
endmodule
